// File: rtl/dmc_pkg.sv
// Shared types and address helpers for the direct-mapped write-through cache.
package dmc_pkg;

    localparam int ADDR_W   = 12;
    localparam int DATA_W   = 32;
    localparam int INDEX_W  = 4;
    localparam int OFFSET_W = 2;
    localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W;
    localparam int LINES    = 1 << INDEX_W;
    localparam int WORDS    = 1 << OFFSET_W;
    localparam int MEM_SIZE = 1 << ADDR_W;

    typedef enum logic {
        READ  = 1'b0,
        WRITE = 1'b1
    } req_e;

    typedef struct packed {
        logic                         valid;
        logic [TAG_W-1:0]             tag;
        logic [WORDS-1:0][DATA_W-1:0] data;
    } line_t;

    function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] a);
        return a[ADDR_W-1 -: TAG_W];
    endfunction

    function automatic logic [INDEX_W-1:0] addr_index(input logic [ADDR_W-1:0] a);
        return a[OFFSET_W +: INDEX_W];
    endfunction

    function automatic logic [OFFSET_W-1:0] addr_offset(input logic [ADDR_W-1:0] a);
        return a[OFFSET_W-1:0];
    endfunction

endpackage

// File: rtl/direct_map_cache_if.sv
// Processor-side request port of the cache: address, write data, read/write select and registered results.
interface direct_map_cache_if;
    import dmc_pkg::*;

    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] data;
    req_e              r_or_w;
    logic [DATA_W-1:0] out;
    logic              hit;

    modport master (output address, data, r_or_w, input out, hit);
    modport slave  (input address, data, r_or_w, output out, hit);

endinterface

// File: rtl/dmc_main_mem.sv
// Backing main memory: synchronous write, asynchronous word read and 4-word block read.
module dmc_main_mem
    import dmc_pkg::*;
(
    input  logic                         clk,
    input  logic                         we,
    input  logic [ADDR_W-1:0]            wr_addr,
    input  logic [DATA_W-1:0]            wr_data,
    input  logic [ADDR_W-1:0]            rd_addr,
    output logic [DATA_W-1:0]            rd_data,
    input  logic [ADDR_W-OFFSET_W-1:0]   blk_addr,
    output logic [WORDS-1:0][DATA_W-1:0] blk_data
);

    // Words are stored XOR-ed with their own address, so an all-zero array
    // reads back as mem[a] = a without any run-time initialisation pass.
    logic [DATA_W-1:0] enc_q [MEM_SIZE] = '{default: '0};

    always_ff @(posedge clk) begin
        if (we) begin
            enc_q[wr_addr] <= wr_data ^ DATA_W'(wr_addr);
        end
    end

    assign rd_data = enc_q[rd_addr] ^ DATA_W'(rd_addr);

    for (genvar w = 0; w < WORDS; w++) begin : g_blk
        localparam logic [OFFSET_W-1:0] OFF = OFFSET_W'(w);
        assign blk_data[w] = enc_q[{blk_addr, OFF}] ^ DATA_W'({blk_addr, OFF});
    end

endmodule

// File: rtl/direct_map_cache.sv
// Direct-mapped write-through cache over dmc_main_mem, one request per clock, 1-cycle latency.
// Optional build macro DMC_WRITE_ALLOCATE_EN turns write misses into allocating writes.
module direct_map_cache
    import dmc_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    direct_map_cache_if.slave  bus
);

    logic [LINES-1:0]             valid_q;
    logic [TAG_W-1:0]             tag_q  [LINES];
    logic [WORDS-1:0][DATA_W-1:0] data_q [LINES];

    logic [TAG_W-1:0]             req_tag;
    logic [INDEX_W-1:0]           req_idx;
    logic [OFFSET_W-1:0]          req_off;
    line_t                        cur;
    logic                         is_hit;
    logic                         is_write;
    logic                         allocate;
    logic                         update_line;
    logic [WORDS-1:0][DATA_W-1:0] next_data;
    logic [DATA_W-1:0]            mem_rd_data;
    logic [WORDS-1:0][DATA_W-1:0] blk_data;

    assign req_tag  = addr_tag(bus.address);
    assign req_idx  = addr_index(bus.address);
    assign req_off  = addr_offset(bus.address);
    assign is_write = (bus.r_or_w == WRITE);

    always_comb begin
        cur.valid = valid_q[req_idx];
        cur.tag   = tag_q[req_idx];
        cur.data  = data_q[req_idx];
    end

    assign is_hit = cur.valid && (cur.tag == req_tag);

`ifdef DMC_WRITE_ALLOCATE_EN
    assign allocate = !is_hit;
`else
    assign allocate = !is_hit && !is_write;
`endif

    assign update_line = allocate || (is_write && is_hit);

    // Refill comes first so an allocating write lands on top of the fresh block.
    always_comb begin
        next_data = allocate ? blk_data : cur.data;
        if (is_write) begin
            next_data[req_off] = bus.data;
        end
    end

    dmc_main_mem u_mem (
        .clk      (clk),
        .we       (rst_n && is_write),
        .wr_addr  (bus.address),
        .wr_data  (bus.data),
        .rd_addr  (bus.address),
        .rd_data  (mem_rd_data),
        .blk_addr ({req_tag, req_idx}),
        .blk_data (blk_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            bus.out <= '0;
            bus.hit <= 1'b0;
        end else begin
            if (update_line) begin
                valid_q[req_idx] <= 1'b1;
                tag_q[req_idx]   <= req_tag;
                data_q[req_idx]  <= next_data;
            end
            bus.hit <= is_hit;
            if (is_write) begin
                bus.out <= bus.data;
            end else if (is_hit) begin
                bus.out <= cur.data[req_off];
            end else begin
                bus.out <= mem_rd_data;
            end
        end
    end

endmodule

// File: tb/tb_direct_map_cache.sv
// Self-checking bench for direct_map_cache: directed table, corner sequences, random traffic vs. a reference model.
module tb_direct_map_cache;
    import dmc_pkg::*;

`ifdef DMC_WRITE_ALLOCATE_EN
    localparam bit WA = 1'b1;
`else
    localparam bit WA = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    direct_map_cache_if bus ();
    direct_map_cache dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: memory contents plus which block tag each line holds.
    logic [31:0] ref_mem   [4096];
    bit          ref_valid [16];
    logic [5:0]  ref_tag   [16];

    typedef struct {
        string       name;
        logic [11:0] addr;
        logic [31:0] data;
        bit          wr;
        logic [31:0] exp_out;
        bit          exp_hit;
    } vec_t;

    vec_t vecs [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 16; i++) ref_valid[i] = 1'b0;
    endfunction

    function automatic void model_op(input logic [11:0] a, input logic [31:0] d, input bit wr,
                                     output logic [31:0] eo, output bit eh);
        int  i = int'(a[5:2]);
        bit  h = ref_valid[i] && (ref_tag[i] == a[11:6]);
        eh = h;
        if (!wr) begin
            eo = ref_mem[a];
            if (!h) begin ref_valid[i] = 1'b1; ref_tag[i] = a[11:6]; end
        end else begin
            ref_mem[a] = d;
            eo = d;
            if (!h && WA) begin ref_valid[i] = 1'b1; ref_tag[i] = a[11:6]; end
        end
    endfunction

    // Drives one request, samples after the edge, and checks against the model.
    task automatic do_op(input string name, input logic [11:0] a, input logic [31:0] d, input bit wr,
                         output logic [31:0] act_out, output bit act_hit);
        logic [31:0] eo;
        bit          eh;
        bus.address = a;
        bus.data    = d;
        bus.r_or_w  = wr ? WRITE : READ;
        @(posedge clk);
        #1;
        act_out = bus.out;
        act_hit = bus.hit;
        model_op(a, d, wr, eo, eh);
        check({name, " model out"}, act_out, eo);
        check({name, " model hit"}, 32'(act_hit), 32'(eh));
    endtask

    task automatic spec_op(input string name, input logic [11:0] a, input logic [31:0] d, input bit wr,
                           input logic [31:0] exp_out, input bit exp_hit);
        logic [31:0] o;
        bit          h;
        do_op(name, a, d, wr, o, h);
        check({name, " out"}, o, exp_out);
        check({name, " hit"}, 32'(h), 32'(exp_hit));
    endtask

    initial begin
        logic [31:0] o;
        bit          h;
        logic [31:0] v;
        logic [11:0] ra;

        for (int a = 0; a < 4096; a++) ref_mem[a] = 32'(a);
        model_reset();
        bus.address = '0;
        bus.data    = '0;
        bus.r_or_w  = READ;

        repeat (2) @(posedge clk);
        #1;
        check("reset out", bus.out, 32'h0);
        check("reset hit", 32'(bus.hit), 32'h0);
        rst_n = 1'b1;

        vecs.push_back('{"rd0 miss",    12'h000, 32'h0,        1'b0, 32'h0,        1'b0});
        vecs.push_back('{"rd1 hit",     12'h001, 32'h0,        1'b0, 32'h1,        1'b1});
        vecs.push_back('{"rd2 hit",     12'h002, 32'h0,        1'b0, 32'h2,        1'b1});
        vecs.push_back('{"rd3 hit",     12'h003, 32'h0,        1'b0, 32'h3,        1'b1});
        vecs.push_back('{"wr1 hit",     12'h001, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1});
        vecs.push_back('{"rd3 again",   12'h003, 32'h0,        1'b0, 32'h3,        1'b1});
        vecs.push_back('{"rd1 new",     12'h001, 32'h0,        1'b0, 32'hFFFFFFFF, 1'b1});
        vecs.push_back('{"rd40 confl",  12'h040, 32'h0,        1'b0, 32'h40,       1'b0});
        vecs.push_back('{"rd0 evicted", 12'h000, 32'h0,        1'b0, 32'h0,        1'b0});
        vecs.push_back('{"wr100 miss",  12'h100, 32'h12345678, 1'b1, 32'h12345678, 1'b0});
        vecs.push_back('{"rd100",       12'h100, 32'h0,        1'b0, 32'h12345678, WA});
        vecs.push_back('{"rd0 recache", 12'h000, 32'h0,        1'b0, 32'h0,        1'b0});
        vecs.push_back('{"rd1 cached",  12'h001, 32'h0,        1'b0, 32'hFFFFFFFF, 1'b1});

        foreach (vecs[i])
            spec_op(vecs[i].name, vecs[i].addr, vecs[i].data, vecs[i].wr, vecs[i].exp_out, vecs[i].exp_hit);

        // Reset mid-sequence: outputs clear at once, memory keeps its writes.
        rst_n = 1'b0;
        #1;
        check("midreset out", bus.out, 32'h0);
        check("midreset hit", 32'(bus.hit), 32'h0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        spec_op("rd1 after reset", 12'h001, 32'h0, 1'b0, 32'hFFFFFFFF, 1'b0);

        // Back-to-back write/read at the top address.
        spec_op("rdFFF first", 12'hFFF, 32'h0, 1'b0, 32'hFFF, 1'b0);
        for (int k = 0; k < 6; k++) begin
            v = $urandom;
            spec_op($sformatf("wrFFF %0d", k), 12'hFFF, v, 1'b1, v, 1'b1);
            spec_op($sformatf("rdFFF %0d", k), 12'hFFF, 32'h0, 1'b0, v, 1'b1);
        end

        // Random traffic, biased to a few tags so hits, conflicts and evictions all occur.
        for (int k = 0; k < 400; k++) begin
            ra = 12'($urandom_range(0, 4095));
            if ($urandom_range(0, 3) != 0) ra[11:6] = 6'($urandom_range(0, 2));
            do_op($sformatf("rand %0d @%03h", k, ra), ra, $urandom, $urandom_range(0, 2) == 0, o, h);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/direct_map_cache.md
# direct_map_cache

Word-addressed, direct-mapped, write-through cache with its own backing main-memory model. One read or write request is serviced on every rising clock edge, and the result is registered onto `out`. The block sits between a simple processor-side request port (address, data, read/write select) and an internal 4096-word main memory. It is intended as a self-contained cache-behaviour model for simulation and small FPGA builds.

## Interface
Parameters:
- `ADDR_W`, 12: word-address width; main memory has 2^ADDR_W words.
- `DATA_W`, 32: data word width.
- `INDEX_W`, 4: line-index bits, giving 16 lines.
- `OFFSET_W`, 2: word-in-block bits, giving 4 words per block.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `address`  in  12  word address of the request.
- `data`  in  32  write data.
- `r_or_w`  in  1  0 = read, 1 = write.
- `out`  out  32  registered result word.
- `hit`  out  1  registered; 1 if the request sampled at the last edge hit in the cache.

## Operation
- Address split: tag = `address[11:6]` (6 bits), index = `address[5:2]`, offset = `address[1:0]`.
- Per line state: valid bit, 6-bit tag, and 4×32 data words.
- Hit condition: line[index] is valid and its tag equals the request tag.
- Main memory: 4096×32. At time zero each word is initialised to its own address zero-extended (mem[a] = a). Reset never alters main memory.
- Read hit: `out` ← line word[offset]; `hit` ← 1.
- Read miss:
  - Refill all 4 words of the block (address with offset = 0..3) from memory into the line in the same edge.
  - Set valid and write the new tag.
  - `out` ← mem[address]; `hit` ← 0.
  - Any previous line contents are discarded; lines are never dirty.
- Write hit:
  - Write `data` to line word[offset] and to mem[address] (write-through).
  - `out` ← `data`; `hit` ← 1.
- Write miss: write mem[address] only; the cache line is unchanged (see Configuration). `out` ← `data`; `hit` ← 0.
- Reset (`rst_n` low):
  - All valid bits cleared; `out` = 0; `hit` = 0.
  - Tags and line data are not reset.
- No handshake. Every rising edge with `rst_n` high performs exactly one operation, and back-to-back requests are always accepted.

## Timing
- Latency is 1 cycle. A request sampled at edge N is reflected in `out`/`hit` immediately after edge N and holds until edge N+1.
- Memory reads are combinational (asynchronous-read array). A miss refill therefore completes within the single cycle, with no stall.
- Read-after-write to the same address on consecutive edges returns the newly written data, whether or not the write hit.
- Reset asserted mid-operation: outputs go to 0 immediately and valid bits clear. Any memory write already completed at a prior edge persists.
- Release of `rst_n` is synchronised by the usual reset synchroniser outside this block. The first operation occurs at the first rising edge with `rst_n` high.
- Requests whose address changes between edges have no effect until sampled.

## Configuration
- `DMC_WRITE_ALLOCATE_EN`:
  - Defined: a write miss first refills the block from memory (tag/valid updated). It then applies the write to both line and memory, exactly as a write hit, in the same edge. `hit` still reports 0.
  - Undefined (default): no-write-allocate, exactly as described in Operation.

## Structure
- Package `dmc_pkg`:
  - ADDR_W/DATA_W/INDEX_W/OFFSET_W/TAG_W constants.
  - `line_t` struct (valid, tag, data[4]).
  - `req_e` enum (READ = 0, WRITE = 1).
  - Address field extraction helpers.
- Sub-module `dmc_main_mem`: 4096×32 array with synchronous write, asynchronous read, and a 4-word block read port. It holds the time-zero initialisation.
- The top level holds the line array, hit logic and output registers.

## Test plan
- Reset then read addresses 0, 1, 2, 3 → `out` = 0 (`hit` = 0), then 1, 2, 3 with `hit` = 1 (block refilled on first miss).
- Write `data` = 0xFFFFFFFF to address 1 (hit) → `out` = 0xFFFFFFFF, `hit` = 1. Then read 3 → 3. Then read 1 → 0xFFFFFFFF, `hit` = 1.
- Conflict: read 0x000, read 0x040 (same index, tag 1) → `out` = 0x40, `hit` = 0. Then read 0x000 → `out` = 0, `hit` = 0 (evicted).
- Write miss to 0x100 with 0x12345678, then read 0x100 → `out` = 0x12345678 and `hit` = 0 (no-allocate). With `DMC_WRITE_ALLOCATE_EN`, the read shows `hit` = 1.
- Assert `rst_n` low mid-sequence after caching block 0 → `out` = 0 and `hit` = 0 immediately. After release, read 1 misses (`hit` = 0) and returns the last written value.
- Back-to-back alternating write/read to address 0xFFF every cycle → each read returns the value written in the preceding cycle; `out` = 0xFFF before the first write.
